// File: rtl/cpu_68k_busctl.sv
// ---------------------------------------------------------------------------
// cpu_68k_busctl
// Bus-cycle controller for a 68000 core running from clock enables derived
// from CLK_48M. It acknowledges ordinary bus cycles after a programmable number
// of wait states, answers interrupt-acknowledge cycles with an autovector
// request, and raises bus error on a stalled cycle. It also latches interrupt
// requests, encodes them onto IPL, and stretches the CPU reset.
//
// Ports
//   CLK_48M       in   sole clock, rising edge
//   RESET         in   synchronous active-high reset
//   CLK_EN_68K_P  in   phi1 enable (not needed by this block)
//   CLK_EN_68K_N  in   phi2 enable; every FSM and counter step happens on it
//   nAS           in   CPU address strobe, active low
//   M68K_RW       in   CPU read/write, 1 = read
//   M68K_ADDR     in   CPU address [23:1]
//   WAIT_STATES   in   wait states for this cycle, sampled at cycle start
//   DEVICE_READY  in   addressed device ready, active high
//   IRQ_REQ       in   interrupt request per source (source i = level i+1)
//   IRQ_CLR       in   software clear per source
//   nDTACK        out  data acknowledge, active low
//   nVPA          out  autovector request, active low
//   nBERR         out  bus error, active low
//   IPL           out  active-low encoded interrupt level
//   IRQ_PENDING   out  pending latches
//   CPU_RESET     out  CPU reset, active high
// ---------------------------------------------------------------------------
module cpu_68k_busctl #(
   parameter int NUM_IRQ    = 3,
   parameter int TIMEOUT    = 255,
   parameter int RESET_HOLD = 16
) (
   input  logic               CLK_48M,
   input  logic               RESET,
   input  logic               CLK_EN_68K_P,
   input  logic               CLK_EN_68K_N,
   input  logic               nAS,
   input  logic               M68K_RW,
   input  logic [23:1]        M68K_ADDR,
   input  logic [3:0]         WAIT_STATES,
   input  logic               DEVICE_READY,
   input  logic [NUM_IRQ-1:0] IRQ_REQ,
   input  logic [NUM_IRQ-1:0] IRQ_CLR,
   output logic               nDTACK,
   output logic               nVPA,
   output logic               nBERR,
   output logic [2:0]         IPL,
   output logic [NUM_IRQ-1:0] IRQ_PENDING,
   output logic               CPU_RESET
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_IACK, S_ERR} state_t;

   state_t             state, state_nxt;
   logic [3:0]         wait_cnt, wait_cnt_nxt;
   logic [9:0]         to_cnt, to_cnt_nxt, to_inc;
   logic [7:0]         hold_cnt;
   logic [NUM_IRQ-1:0] irq_req_p1;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] iack_clr;
   logic               dtack_nxt, vpa_nxt, berr_nxt;
   logic               unused_en_p;

   assign unused_en_p = CLK_EN_68K_P;

   // Highest pending level (source i is level i+1); 0 when nothing pending.
   function automatic logic [2:0] highest_level(input logic [NUM_IRQ-1:0] p);
      logic [2:0] lvl;
      lvl = 3'd0;
      for (int i = 0; i < NUM_IRQ; i++)
         if (p[i]) lvl = 3'(i + 1);
      return lvl;
   endfunction

   // ---- state register ----
   always_ff @(posedge CLK_48M) begin
      if (RESET) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         to_cnt   <= '0;
         nDTACK   <= 1'b1;
         nVPA     <= 1'b1;
         nBERR    <= 1'b1;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         to_cnt   <= to_cnt_nxt;
         // Strobes are registered copies of the decoded next state, so they
         // change on exactly the edge the FSM moves.
         nDTACK   <= dtack_nxt;
         nVPA     <= vpa_nxt;
         nBERR    <= berr_nxt;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      to_cnt_nxt   = to_cnt;
      iack_clr     = '0;
      to_inc       = to_cnt + 10'd1;
      if (CPU_RESET) begin
         state_nxt    = S_IDLE;
         wait_cnt_nxt = '0;
         to_cnt_nxt   = '0;
      end else if (CLK_EN_68K_N) begin
         case (state)
            S_IDLE: begin
               if (!nAS) begin
                  if (M68K_RW && (&M68K_ADDR[23:4])) begin
                     state_nxt = S_IACK;
                     // Levels 0 and above NUM_IRQ match no source.
                     for (int i = 0; i < NUM_IRQ; i++)
                        iack_clr[i] = (M68K_ADDR[3:1] == 3'(i + 1));
                  end else begin
                     state_nxt    = S_WAIT;
                     wait_cnt_nxt = WAIT_STATES;
                     to_cnt_nxt   = '0;
                  end
               end
            end
            S_WAIT: begin
               wait_cnt_nxt = (wait_cnt == 4'd0) ? 4'd0 : wait_cnt - 4'd1;
               to_cnt_nxt   = to_inc;
               // Abort first; ACK is tested ahead of timeout so it wins a tie.
               if (nAS)
                  state_nxt = S_IDLE;
               else if ((wait_cnt == 4'd0) && DEVICE_READY)
                  state_nxt = S_ACK;
               else if (to_inc == 10'(TIMEOUT))
                  state_nxt = S_ERR;
            end
            S_ACK, S_IACK, S_ERR: begin
               if (nAS) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ---- output decode ----
   always_comb begin
      dtack_nxt = 1'b1;
      vpa_nxt   = 1'b1;
      berr_nxt  = 1'b1;
      case (state_nxt)
         S_ACK:   dtack_nxt = 1'b0;
         S_IACK:  vpa_nxt   = 1'b0;
         S_ERR:   berr_nxt  = 1'b0;
         default: ;
      endcase
   end

   // ---- interrupt latches, IPL encode, CPU reset stretch ----
   assign irq_rise = IRQ_REQ & ~irq_req_p1;

   always_ff @(posedge CLK_48M) begin
      if (RESET) begin
         irq_req_p1  <= '0;
         IRQ_PENDING <= '0;
         IPL         <= 3'b111;
         CPU_RESET   <= 1'b1;
         hold_cnt    <= 8'(RESET_HOLD);
      end else begin
         irq_req_p1  <= IRQ_REQ;
         // A new edge overrides any clear arriving in the same cycle.
         IRQ_PENDING <= (IRQ_PENDING & ~IRQ_CLR & ~iack_clr) | irq_rise;
         if (CLK_EN_68K_N) begin
            IPL <= ~highest_level(IRQ_PENDING);
            if (CPU_RESET) begin
               if (hold_cnt <= 8'd1) begin
                  CPU_RESET <= 1'b0;
                  hold_cnt  <= 8'd0;
               end else begin
                  hold_cnt  <= hold_cnt - 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: doc/cpu_68k_busctl.md
CPU_68K_BUSCTL -- requirements
Module: cpu_68k_busctl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 3, meaning the number of interrupt sources (1..7); source i maps to level i+1.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the number of bus-wait phi2 enables before bus error (1..1023).
REQ-003 SHALL have parameter RESET_HOLD, default 16, meaning the number of phi2 enables CPU_RESET is held after RESET falls (1..255).
REQ-004 SHALL have port CLK_48M  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port CLK_EN_68K_P  in  1  phi1 clock enable.
REQ-007 SHALL have port CLK_EN_68K_N  in  1  phi2 clock enable; all FSM and counter steps occur only on it.
REQ-008 SHALL have port nAS  in  1  CPU address strobe, active low.
REQ-009 SHALL have port M68K_RW  in  1  CPU read/write, 1 = read.
REQ-010 SHALL have port M68K_ADDR  in  23  CPU address [23:1].
REQ-011 SHALL have port WAIT_STATES  in  4  wait-state count for the current cycle, sampled at cycle start.
REQ-012 SHALL have port DEVICE_READY  in  1  addressed device ready, active high.
REQ-013 SHALL have port IRQ_REQ  in  NUM_IRQ  interrupt request per source; rising edge sets pending.
REQ-014 SHALL have port IRQ_CLR  in  NUM_IRQ  software clear per source, active high.
REQ-015 SHALL have port nDTACK  out  1  data acknowledge, active low.
REQ-016 SHALL have port nVPA  out  1  autovector request, active low.
REQ-017 SHALL have port nBERR  out  1  bus error, active low.
REQ-018 SHALL have port IPL  out  3  active-low encoded interrupt level {IPL2,IPL1,IPL0}.
REQ-019 SHALL have port IRQ_PENDING  out  NUM_IRQ  pending latches.
REQ-020 SHALL have port CPU_RESET  out  1  CPU reset, active high.

Function
REQ-021 SHALL implement bus FSM states IDLE, WAIT, ACK, IACK, ERR, stepping only on CLK_EN_68K_N.
REQ-022 SHALL, in IDLE with nAS=0, go to IACK if M68K_RW=1 and M68K_ADDR[23:4] all ones, else to WAIT loading wait counter with WAIT_STATES and clearing timeout counter.
REQ-023 SHALL, in WAIT, decrement the wait counter per phi2 enable (saturating at 0) and increment the timeout counter.
REQ-024 SHALL go WAIT->ACK when wait counter is 0 and DEVICE_READY=1; WAIT_STATES=0 with ready gives nDTACK low on the phi2 enable after entry to WAIT.
REQ-025 SHALL go WAIT->ERR when the timeout counter reaches TIMEOUT without ACK; ACK wins if both occur on the same enable.
REQ-026 SHALL go WAIT->IDLE with no strobe asserted if nAS=1 is sampled in WAIT.
REQ-027 SHALL drive nDTACK=0 only in ACK, nVPA=0 only in IACK, nBERR=0 only in ERR, all registered.
REQ-028 SHALL leave ACK, IACK or ERR for IDLE on the first phi2 enable sampling nAS=1, deasserting the strobe at that same edge.
REQ-029 SHALL, on IACK entry, clear pending bit L-1 where L=M68K_ADDR[3:1], if 1<=L<=NUM_IRQ; other levels clear nothing yet still assert nVPA.
REQ-030 SHALL set IRQ_PENDING[i] on a 0->1 transition of IRQ_REQ[i], detected every CLK_48M cycle.
REQ-031 SHALL clear IRQ_PENDING[i] when IRQ_CLR[i]=1; set SHALL win over simultaneous IRQ_CLR or IACK clear.
REQ-032 SHALL update IPL on each phi2 enable to the bitwise inverse of the highest pending level, 3'b111 when none pending.
REQ-033 SHALL hold CPU_RESET=1 for RESET_HOLD phi2 enables after RESET falls, then drive 0.
REQ-034 SHALL force the bus FSM to IDLE and all strobes high while CPU_RESET=1; pending latching SHALL continue.

Reset
REQ-035 SHALL, while RESET=1, drive nDTACK=1, nVPA=1, nBERR=1, IPL=3'b111, IRQ_PENDING=0, CPU_RESET=1, FSM=IDLE, all counters 0, hold counter loaded with RESET_HOLD.
REQ-036 SHALL treat RESET asserted mid-cycle identically, deasserting any active strobe on the next CLK_48M edge.
REQ-037 SHALL capture IRQ_REQ edge-detect history as 0 in reset, so a source high at reset release sets pending.

Verification
REQ-038 SHALL verify reset: RESET high 5 cycles, low -> CPU_RESET falls after exactly 16 phi2 enables; strobes high, IPL=111.
REQ-039 SHALL verify wait states: read at 0x001000, WAIT_STATES=3, DEVICE_READY=1 -> nDTACK low on 4th phi2 enable after cycle start, high on first enable with nAS=1.
REQ-040 SHALL verify timeout: DEVICE_READY=0, TIMEOUT=255 -> nBERR low after 255 enables, nDTACK never low.
REQ-041 SHALL verify priority: pulse IRQ_REQ[0] and IRQ_REQ[2] -> IPL=3'b100; IACK at 0xFFFFF6 (L=3) -> nVPA low, pending=3'b001, IPL=3'b110.
REQ-042 SHALL verify set-over-clear: IRQ_REQ[1] rising with IRQ_CLR[1]=1 same cycle -> IRQ_PENDING[1]=1.
REQ-043 SHALL verify abort: nAS released during WAIT with WAIT_STATES=15 -> FSM IDLE, no strobe asserted.
